// File: rtl/gb_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gb_mem_pkg
//  Purpose  : Shared types, memory-map constants and the address decoder
//             used by the memory-side responder and its OAM DMA engine.
//  Contents : region_t, dma_state_t, address constants, decode_region().
//  Revision : 1.0  initial release
// ============================================================================
package gb_mem_pkg;

   typedef enum logic [2:0] {
      RGN_ROM      = 3'd0,
      RGN_WRAM     = 3'd1,
      RGN_HRAM     = 3'd2,
      RGN_DMA_REG  = 3'd3,
      RGN_UNMAPPED = 3'd4
   } region_t;

   typedef enum logic [1:0] {
      DMA_IDLE  = 2'd0,
      DMA_START = 2'd1,
      DMA_XFER  = 2'd2
   } dma_state_t;

   localparam logic [15:0] ROM_END      = 16'h7FFF;
   localparam logic [15:0] WRAM_BASE    = 16'hC000;
   localparam logic [15:0] ECHO_END     = 16'hFDFF;
   localparam logic [15:0] OAM_BASE     = 16'hFE00;
   localparam logic [15:0] OAM_END      = 16'hFE9F;
   localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
   localparam logic [15:0] HRAM_BASE    = 16'hFF80;
   localparam logic [15:0] HRAM_END     = 16'hFFFE;

   localparam int DMA_LEN_DEFAULT = 160;

   // CPU-visible region for an address. OAM is not readable here and
   // decodes as unmapped; OAM writes are detected separately.
   function automatic region_t decode_region(input logic [15:0] i_addr);
      region_t w_rgn;
      if (i_addr <= ROM_END)
         w_rgn = RGN_ROM;
      else if (i_addr >= WRAM_BASE && i_addr <= ECHO_END)
         w_rgn = RGN_WRAM;
      else if (i_addr == DMA_REG_ADDR)
         w_rgn = RGN_DMA_REG;
      else if (i_addr >= HRAM_BASE && i_addr <= HRAM_END)
         w_rgn = RGN_HRAM;
      else
         w_rgn = RGN_UNMAPPED;
      return w_rgn;
   endfunction

endpackage : gb_mem_pkg
`default_nettype wire

// File: rtl/oam_dma.sv
`default_nettype none
// ============================================================================
//  Module   : oam_dma
//  Purpose  : OAM DMA engine. Sequences IDLE -> START -> XFER -> IDLE,
//             generates source addresses and the pipelined OAM write strobe.
//  Ports    : i_clk, i_rst_n        clock, async active-low reset
//             i_start, i_src_hi     start/restart strobe and source page
//             o_bus_req             DMA drives the read address this cycle
//             o_src_addr            {source page, byte counter}
//             o_oam_wr_en/o_oam_idx OAM write strobe and byte index
//             o_active              DMA owns the bus
//  Revision : 1.0  initial release
// ============================================================================
module oam_dma
   import gb_mem_pkg::*;
#(
   parameter int DMA_LEN = DMA_LEN_DEFAULT
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic [7:0]  i_src_hi,
   output logic        o_bus_req,
   output logic [15:0] o_src_addr,
   output logic        o_oam_wr_en,
   output logic [7:0]  o_oam_idx,
   output logic        o_active
);

   localparam logic [7:0] C_LAST_IDX = 8'(DMA_LEN - 1);

   dma_state_t r_state;
   dma_state_t w_state_nxt;
   logic [7:0] r_cnt;
   logic [7:0] r_src_hi;
   logic [7:0] r_idx;
   logic       r_wr_en;
   logic       w_last;

   assign w_last = (r_state == DMA_XFER) && (r_cnt == C_LAST_IDX);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_state <= DMA_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (i_start) begin
         // A start while busy restarts the whole sequence.
         w_state_nxt = DMA_START;
      end else begin
         case (r_state)
            DMA_IDLE:  w_state_nxt = DMA_IDLE;
            DMA_START: w_state_nxt = DMA_XFER;
            DMA_XFER:  w_state_nxt = w_last ? DMA_IDLE : DMA_XFER;
            default:   w_state_nxt = DMA_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt    <= 8'h00;
         r_src_hi <= 8'h00;
         r_idx    <= 8'h00;
         r_wr_en  <= 1'b0;
      end else begin
         if (i_start) begin
            r_src_hi <= i_src_hi;
            r_cnt    <= 8'h00;
         end else if (r_state == DMA_XFER) begin
            r_cnt <= w_last ? 8'h00 : r_cnt + 8'h01;
         end
         // The byte read this cycle is written next cycle; a restart
         // discards the in-flight byte so OAM writes resume at index 0.
         r_wr_en <= (r_state == DMA_XFER) && !i_start;
         if (r_state == DMA_XFER)
            r_idx <= r_cnt;
      end
   end

   assign o_bus_req   = (r_state == DMA_XFER);
   assign o_src_addr  = {r_src_hi, r_cnt};
   assign o_oam_wr_en = r_wr_en;
   assign o_oam_idx   = r_idx;
   // Stays high through the final write cycle after XFER ends.
   assign o_active    = (r_state != DMA_IDLE) || r_wr_en;

endmodule : oam_dma
`default_nettype wire

// File: rtl/mem_bus.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus
//  Purpose  : Memory-side responder for the CPU. Decodes reads and writes,
//             holds WRAM/HRAM and the DMA register, forwards ROM reads to
//             the cartridge and OAM writes to the PPU, hosts the OAM DMA.
//  Ports    : i_clk, i_rst_n                 clock, async active-low reset
//             i_cpu_rd_addr / o_cpu_rd_data   CPU read (one-edge latency)
//             i_cpu_wr_en/_addr/_data         CPU write
//             o_rom_addr / i_rom_data         cartridge ROM port
//             o_oam_wr_en/_addr/_wr_data      PPU OAM write port
//             o_dma_active                    DMA owns the bus
//  Revision : 1.0  initial release
// ============================================================================
module mem_bus
   import gb_mem_pkg::*;
#(
   parameter int WRAM_BYTES = 8192,
   parameter int HRAM_BYTES = 127,
   parameter int DMA_LEN    = DMA_LEN_DEFAULT
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [15:0] i_cpu_rd_addr,
   output logic [7:0]  o_cpu_rd_data,
   input  logic        i_cpu_wr_en,
   input  logic [15:0] i_cpu_wr_addr,
   input  logic [7:0]  i_cpu_wr_data,
   output logic [14:0] o_rom_addr,
   input  logic [7:0]  i_rom_data,
   output logic        o_oam_wr_en,
   output logic [7:0]  o_oam_addr,
   output logic [7:0]  o_oam_wr_data,
   output logic        o_dma_active
);

   localparam int WRAM_AW = $clog2(WRAM_BYTES);
   localparam int HRAM_AW = $clog2(HRAM_BYTES);

   // ---------------------------------------------------------------- DMA
   logic        w_dma_start;
   logic        w_dma_bus_req;
   logic [15:0] w_dma_src_addr;
   logic        w_dma_oam_wr_en;
   logic [7:0]  w_dma_oam_idx;
   logic        w_dma_active;

   // ------------------------------------------------------------- decode
   region_t w_rd_region;
   region_t w_wr_region;
   region_t w_dma_src_region;
   logic    w_wr_is_oam;
   logic    w_wram_we;
   logic    w_hram_we;
   logic    w_cpu_oam_we;

   logic [WRAM_AW-1:0] w_wram_rd_idx;
   logic [WRAM_AW-1:0] w_wram_wr_idx;
   logic [HRAM_AW-1:0] w_hram_rd_idx;
   logic [HRAM_AW-1:0] w_hram_wr_idx;

   // ---------------------------------------------------------- registers
   region_t     r_rd_region;
   region_t     r_dma_src_region;
   logic [14:0] r_rom_addr;
   logic [7:0]  r_dma_reg;
   logic        r_cpu_oam_en;
   logic [7:0]  r_cpu_oam_addr;
   logic [7:0]  r_cpu_oam_data;

   logic [7:0]  r_wram [WRAM_BYTES];
   logic [7:0]  r_hram [HRAM_BYTES];
   logic [7:0]  r_wram_q;
   logic [7:0]  r_hram_q;

   logic [7:0]  w_dma_rd_data;

   oam_dma #(
      .DMA_LEN (DMA_LEN)
   ) u_oam_dma (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_start     (w_dma_start),
      .i_src_hi    (i_cpu_wr_data),
      .o_bus_req   (w_dma_bus_req),
      .o_src_addr  (w_dma_src_addr),
      .o_oam_wr_en (w_dma_oam_wr_en),
      .o_oam_idx   (w_dma_oam_idx),
      .o_active    (w_dma_active)
   );

   assign w_rd_region = decode_region(i_cpu_rd_addr);
   assign w_wr_region = decode_region(i_cpu_wr_addr);
   assign w_wr_is_oam = (i_cpu_wr_addr >= OAM_BASE) && (i_cpu_wr_addr <= OAM_END);

   // While DMA is active only HRAM and the DMA register accept CPU writes.
   assign w_dma_start  = i_cpu_wr_en && (w_wr_region == RGN_DMA_REG);
   assign w_wram_we    = i_cpu_wr_en && !w_dma_active && (w_wr_region == RGN_WRAM);
   assign w_hram_we    = i_cpu_wr_en && (w_wr_region == RGN_HRAM);
   assign w_cpu_oam_we = i_cpu_wr_en && !w_dma_active && w_wr_is_oam;

   // DMA source page: 00-7F ROM, C0-FF WRAM (echo folds via low bits), else open bus.
   always_comb begin
      w_dma_src_region = RGN_UNMAPPED;
      if (w_dma_src_addr[15:8] < 8'h80)
         w_dma_src_region = RGN_ROM;
      else if (w_dma_src_addr[15:8] >= 8'hC0)
         w_dma_src_region = RGN_WRAM;
   end

   // Echo region E000-FDFF aliases C000-DDFF through the low address bits.
   assign w_wram_rd_idx = w_dma_bus_req ? w_dma_src_addr[WRAM_AW-1:0]
                                        : i_cpu_rd_addr[WRAM_AW-1:0];
   assign w_wram_wr_idx = i_cpu_wr_addr[WRAM_AW-1:0];
   assign w_hram_rd_idx = i_cpu_rd_addr[HRAM_AW-1:0];
   assign w_hram_wr_idx = i_cpu_wr_addr[HRAM_AW-1:0];

   // RAM arrays: no reset; read-before-write within the same edge.
   always_ff @(posedge i_clk) begin
      if (w_wram_we)
         r_wram[w_wram_wr_idx] <= i_cpu_wr_data;
      r_wram_q <= r_wram[w_wram_rd_idx];
   end

   always_ff @(posedge i_clk) begin
      if (w_hram_we)
         r_hram[w_hram_wr_idx] <= i_cpu_wr_data;
      // Index 7F (FFFF) is outside the array, so only read on a real hit.
      if (w_rd_region == RGN_HRAM)
         r_hram_q <= r_hram[w_hram_rd_idx];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_region      <= RGN_UNMAPPED;
         r_dma_src_region <= RGN_UNMAPPED;
         r_rom_addr       <= 15'h0000;
         r_dma_reg        <= 8'hFF;
         r_cpu_oam_en     <= 1'b0;
         r_cpu_oam_addr   <= 8'h00;
         r_cpu_oam_data   <= 8'h00;
      end else begin
         r_rd_region      <= (w_dma_active && (w_rd_region != RGN_HRAM)) ? RGN_UNMAPPED
                                                                          : w_rd_region;
         r_dma_src_region <= w_dma_bus_req ? w_dma_src_region : RGN_UNMAPPED;
         r_rom_addr       <= w_dma_bus_req ? w_dma_src_addr[14:0] : i_cpu_rd_addr[14:0];
         if (w_dma_start)
            r_dma_reg <= i_cpu_wr_data;
         r_cpu_oam_en <= w_cpu_oam_we;
         if (w_cpu_oam_we) begin
            r_cpu_oam_addr <= i_cpu_wr_addr[7:0];
            r_cpu_oam_data <= i_cpu_wr_data;
         end
      end
   end

   always_comb begin
      case (r_rd_region)
         RGN_ROM:     o_cpu_rd_data = i_rom_data;
         RGN_WRAM:    o_cpu_rd_data = r_wram_q;
         RGN_HRAM:    o_cpu_rd_data = r_hram_q;
         RGN_DMA_REG: o_cpu_rd_data = r_dma_reg;
         default:     o_cpu_rd_data = 8'hFF;
      endcase
   end

   always_comb begin
      case (r_dma_src_region)
         RGN_ROM:  w_dma_rd_data = i_rom_data;
         RGN_WRAM: w_dma_rd_data = r_wram_q;
         default:  w_dma_rd_data = 8'hFF;
      endcase
   end

   // DMA wins the OAM port; CPU OAM writes are already blocked while active.
   always_comb begin
      o_oam_wr_en   = w_dma_oam_wr_en || r_cpu_oam_en;
      o_oam_addr    = r_cpu_oam_addr;
      o_oam_wr_data = 8'h00;
      if (w_dma_oam_wr_en) begin
         o_oam_addr    = w_dma_oam_idx;
         o_oam_wr_data = w_dma_rd_data;
      end else if (r_cpu_oam_en) begin
         o_oam_wr_data = r_cpu_oam_data;
      end
   end

   assign o_rom_addr   = r_rom_addr;
   assign o_dma_active = w_dma_active;

endmodule : mem_bus
`default_nettype wire

// File: tb/tb_mem_bus.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus
//  Purpose  : Directed self-checking bench for mem_bus. ROM is modelled as
//             data = addr[7:0] ^ 0x31; an OAM monitor logs every strobe.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_bus;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] rd_addr = 16'h0000;
   logic [7:0]  rd_data;
   logic        wr_en = 1'b0;
   logic [15:0] wr_addr = 16'h0000;
   logic [7:0]  wr_data = 8'h00;
   logic [14:0] rom_addr;
   logic [7:0]  rom_data;
   logic        oam_wr_en;
   logic [7:0]  oam_addr;
   logic [7:0]  oam_wr_data;
   logic        dma_active;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int act_cnt = 0;
   int start_cyc = 0;
   int log_addr[$];
   int log_data[$];
   int log_cyc[$];

   always #5 clk = ~clk;

   assign rom_data = rom_addr[7:0] ^ 8'h31;

   mem_bus dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_cpu_rd_addr (rd_addr),
      .o_cpu_rd_data (rd_data),
      .i_cpu_wr_en   (wr_en),
      .i_cpu_wr_addr (wr_addr),
      .i_cpu_wr_data (wr_data),
      .o_rom_addr    (rom_addr),
      .i_rom_data    (rom_data),
      .o_oam_wr_en   (oam_wr_en),
      .o_oam_addr    (oam_addr),
      .o_oam_wr_data (oam_wr_data),
      .o_dma_active  (dma_active)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (dma_active)
         act_cnt = act_cnt + 1;
      if (oam_wr_en) begin
         log_addr.push_back(int'(oam_addr));
         log_data.push_back(int'(oam_wr_data));
         log_cyc.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      wr_en = 1'b1;
      wr_addr = a;
      wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a);
      rd_addr = a;
      tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
      log_cyc.delete();
   endtask

   task automatic wait_idle(input int max_cycles);
      int n;
      n = 0;
      while (dma_active && n < max_cycles) begin
         tick();
         n++;
      end
      chk("dma_finished", 32'(dma_active), 32'd0);
   endtask

   initial begin
      int nlog;

      // ---------------- reset
      #2 rst_n = 1'b0;
      #2;
      chk("rst_active", 32'(dma_active), 32'd0);
      chk("rst_oam_en", 32'(oam_wr_en), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'hFF);
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      chk("rst_oam_addr", 32'(oam_addr), 32'd0);
      chk("rst_oam_data", 32'(oam_wr_data), 32'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // ---------------- basic reads
      rd(16'h0000); chk("rom_0000", 32'(rd_data), 32'h31);
      rd(16'h0005); chk("rom_0005", 32'(rd_data), 32'h34);
      chk("rom_addr_0005", 32'(rom_addr), 32'h0005);
      rd(16'hA000); chk("rd_A000", 32'(rd_data), 32'hFF);
      rd(16'hFE00); chk("rd_FE00", 32'(rd_data), 32'hFF);
      chk("idle_active", 32'(dma_active), 32'd0);

      // ---------------- WRAM / echo / HRAM
      wr(16'hC123, 8'h5A);
      rd(16'hE123); chk("echo_E123", 32'(rd_data), 32'h5A);
      rd(16'hC123); chk("wram_C123", 32'(rd_data), 32'h5A);
      wr(16'hFF80, 8'h77);
      rd(16'hFF80); chk("hram_FF80", 32'(rd_data), 32'h77);
      rd(16'hFFFF); chk("rd_FFFF", 32'(rd_data), 32'hFF);

      // read-first on simultaneous read/write of the same WRAM byte
      wr(16'hC200, 8'h11);
      rd_addr = 16'hC200;
      wr(16'hC200, 8'h22);
      chk("read_first_old", 32'(rd_data), 32'h11);
      rd(16'hC200); chk("read_first_new", 32'(rd_data), 32'h22);

      // CPU OAM write outside DMA: one strobe the cycle after
      clear_log();
      wr(16'hFE05, 8'h66);
      tick();
      chk("cpu_oam_cnt", 32'(log_addr.size()), 32'd1);
      if (log_addr.size() > 0) begin
         chk("cpu_oam_addr", 32'(log_addr[0]), 32'h05);
         chk("cpu_oam_data", 32'(log_data[0]), 32'h66);
      end

      // ---------------- preload WRAM sources
      for (int i = 0; i < 160; i++) wr(16'hC000 + 16'(i), 8'(i) ^ 8'hA5);
      for (int i = 0; i < 160; i++) wr(16'hDE00 + 16'(i), 8'(i) ^ 8'h5C);

      // ---------------- DMA from C000 with CPU traffic during it
      clear_log();
      wr(16'hFF46, 8'hC0);
      start_cyc = cyc;
      act_cnt = 0;
      chk("dma1_cycle1_active", 32'(dma_active), 32'd1);
      chk("dma1_cycle1_no_wr", 32'(oam_wr_en), 32'd0);
      rd(16'hC000); chk("dma1_cpu_rd_wram", 32'(rd_data), 32'hFF);
      wr(16'hC000, 8'h99);
      wr(16'hFF90, 8'h3C);
      rd(16'hFF90); chk("dma1_hram_rd", 32'(rd_data), 32'h3C);
      wr(16'hFE10, 8'h55);
      wait_idle(400);
      chk("dma1_active_cycles", 32'(act_cnt), 32'd162);
      chk("dma1_wr_count", 32'(log_addr.size()), 32'd160);
      if (log_cyc.size() == 160) begin
         chk("dma1_first_cycle", 32'(log_cyc[0] - start_cyc + 1), 32'd3);
         chk("dma1_last_cycle", 32'(log_cyc[159] - start_cyc + 1), 32'd162);
      end
      for (int i = 0; i < 160 && i < log_addr.size(); i++) begin
         chk("dma1_addr", 32'(log_addr[i]), 32'(i));
         chk("dma1_data", 32'(log_data[i]), 32'(8'(i) ^ 8'hA5));
      end
      rd(16'hC000); chk("dma1_dropped_wr", 32'(rd_data), 32'hA5);
      rd(16'hFF46); chk("dma_reg_C0", 32'(rd_data), 32'hC0);

      // ---------------- ROM DMA restarted at byte 50 towards DE00
      clear_log();
      wr(16'hFF46, 8'h00);
      act_cnt = 0;
      repeat (51) tick();
      wr(16'hFF46, 8'hFE);
      wait_idle(400);
      chk("dma2_active_cycles", 32'(act_cnt), 32'd214);
      chk("dma2_wr_count", 32'(log_addr.size()), 32'd210);
      for (int i = 0; i < 210 && i < log_addr.size(); i++) begin
         if (i < 50) begin
            chk("dma2_rom_addr", 32'(log_addr[i]), 32'(i));
            chk("dma2_rom_data", 32'(log_data[i]), 32'(8'(i) ^ 8'h31));
         end else begin
            chk("dma2_wram_addr", 32'(log_addr[i]), 32'(i - 50));
            chk("dma2_wram_data", 32'(log_data[i]), 32'(8'(i - 50) ^ 8'h5C));
         end
      end

      // ---------------- reset at byte 80
      clear_log();
      wr(16'hFF46, 8'hC0);
      repeat (81) tick();
      rst_n = 1'b0;
      #1;
      chk("rst_mid_oam_en", 32'(oam_wr_en), 32'd0);
      chk("rst_mid_active", 32'(dma_active), 32'd0);
      nlog = log_addr.size();
      chk("rst_mid_wr_count", 32'(nlog), 32'd79);
      @(posedge clk);
      #1 rst_n = 1'b1;
      act_cnt = 0;
      repeat (200) tick();
      chk("rst_mid_no_more_wr", 32'(log_addr.size()), 32'(nlog));
      chk("rst_mid_no_active", 32'(act_cnt), 32'd0);
      rd(16'hFF46); chk("rst_mid_dma_reg", 32'(rd_data), 32'hFF);

      // ---------------- next DMA starts from byte 0
      clear_log();
      wr(16'hFF46, 8'hC0);
      act_cnt = 0;
      wait_idle(400);
      chk("dma4_active_cycles", 32'(act_cnt), 32'd162);
      chk("dma4_wr_count", 32'(log_addr.size()), 32'd160);
      if (log_addr.size() > 0) begin
         chk("dma4_first_addr", 32'(log_addr[0]), 32'd0);
         chk("dma4_first_data", 32'(log_data[0]), 32'hA5);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_mem_bus
`default_nettype wire
